// File: rtl/chip_serializer_tx.sv
// Zigbee baseband transmit serializer: frames bytes with an alternating-bit
// preamble, sends them NRZ LSB first at one bit per BIT_CYCLES clocks, then idles for a gap.
module chip_serializer_tx #(
  parameter int unsigned BIT_CYCLES    = 25,
  parameter int unsigned PREAMBLE_BITS = 32,
  parameter int unsigned GAP_BITS      = 2,
  parameter logic        IDLE_LEVEL    = 1'b0
) (
  input  logic       clk,
  input  logic       resetn_i,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  input  logic       byte_last_i,
  output logic       byte_ready_o,
  output logic       data_o,
  output logic       bit_strobe_o,
  output logic       busy_o,
  output logic       underrun_o
);

  localparam int unsigned CW   = $clog2(BIT_CYCLES);
  localparam int unsigned M1   = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int unsigned MAXB = (GAP_BITS > M1) ? GAP_BITS : M1;
  localparam int unsigned BW   = $clog2(MAXB);

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] PRE_LAST = BW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0] GAP_LAST = BW'(GAP_BITS - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(7);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [8:0]    hold_q, hold_d;
  logic          hold_valid_q, hold_valid_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          last_q, last_d;
  logic          flush_q, flush_d;
  logic          data_q, data_d;
  logic          strobe_q, strobe_d;
  logic          underrun_q, underrun_d;
  logic          wrap, accept, load;

  assign wrap   = (cyc_q == CYC_LAST);
  assign accept = byte_valid_i && !hold_valid_q;

  always_comb begin
    state_d      = state_q;
    cyc_d        = wrap ? '0 : cyc_q + 1'b1;
    bitcnt_d     = bitcnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shreg_d      = shreg_q;
    last_d       = last_q;
    flush_d      = flush_q;
    data_d       = data_q;
    strobe_d     = 1'b0;
    underrun_d   = 1'b0;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        cyc_d  = '0;
        data_d = IDLE_LEVEL;
        if (hold_valid_q && !flush_q) begin
          state_d  = PREAMBLE;
          bitcnt_d = '0;
          data_d   = 1'b1;
          strobe_d = 1'b1;
        end
      end
      PREAMBLE: if (wrap) begin
        strobe_d = 1'b1;
        if (bitcnt_q == PRE_LAST) begin
          state_d  = DATA;
          bitcnt_d = '0;
          load     = 1'b1;
          data_d   = hold_q[0];
        end else begin
          // next preamble bit k = bitcnt+1, whose level ~k[0] equals bitcnt[0]
          bitcnt_d = bitcnt_q + 1'b1;
          data_d   = bitcnt_q[0];
        end
      end
      DATA: if (wrap) begin
        if (bitcnt_q == BYTE_LAST) begin
          bitcnt_d = '0;
          if (last_q) begin
            state_d = GAP;
            data_d  = IDLE_LEVEL;
          end else if (hold_valid_q) begin
            load     = 1'b1;
            data_d   = hold_q[0];
            strobe_d = 1'b1;
          end else begin
            state_d    = GAP;
            data_d     = IDLE_LEVEL;
            underrun_d = 1'b1;
            flush_d    = 1'b1;
          end
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
          shreg_d  = shreg_q >> 1;
          data_d   = shreg_q[1];
          strobe_d = 1'b1;
        end
      end
      GAP: if (wrap) begin
        if (bitcnt_q == GAP_LAST) begin
          state_d  = IDLE;
          bitcnt_d = '0;
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shreg_d      = hold_q[7:0];
      last_d       = hold_q[8];
      hold_valid_d = 1'b0;
    end

    // load needs hold_valid set and accept needs it clear, so they never coincide
    if (accept) begin
      if (flush_q) begin
        if (byte_last_i) flush_d = 1'b0;
      end else begin
        hold_d       = {byte_last_i, byte_i};
        hold_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      bitcnt_q     <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shreg_q      <= '0;
      last_q       <= 1'b0;
      flush_q      <= 1'b0;
      data_q       <= IDLE_LEVEL;
      strobe_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bitcnt_q     <= bitcnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shreg_q      <= shreg_d;
      last_q       <= last_d;
      flush_q      <= flush_d;
      data_q       <= data_d;
      strobe_q     <= strobe_d;
      underrun_q   <= underrun_d;
    end
  end

  assign byte_ready_o = ~hold_valid_q;
  assign data_o       = data_q;
  assign bit_strobe_o = strobe_q;
  assign busy_o       = (state_q != IDLE);
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_chip_serializer_tx.sv
// Directed bench for chip_serializer_tx: checks every cycle of each frame
// against bit timing derived from the parameters and the payload bytes.
module tb_chip_serializer_tx;

  localparam int unsigned BC  = 25;
  localparam int unsigned PB  = 32;
  localparam int unsigned GB  = 2;
  localparam logic        IDL = 1'b0;

  logic       clk = 1'b0;
  logic       resetn_i;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       byte_last_i;
  logic       byte_ready_o;
  logic       data_o;
  logic       bit_strobe_o;
  logic       busy_o;
  logic       underrun_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  tx_q[$];

  chip_serializer_tx #(
    .BIT_CYCLES   (BC),
    .PREAMBLE_BITS(PB),
    .GAP_BITS     (GB),
    .IDLE_LEVEL   (IDL)
  ) dut (
    .clk         (clk),
    .resetn_i    (resetn_i),
    .byte_i      (byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_last_i (byte_last_i),
    .byte_ready_o(byte_ready_o),
    .data_o      (data_o),
    .bit_strobe_o(bit_strobe_o),
    .busy_o      (busy_o),
    .underrun_o  (underrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Presents a byte (valid stays high on return) and returns at the negedge
  // after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int unsigned guard = 0;
    byte_i       = b;
    byte_last_i  = last;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!byte_ready_o) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge after the edge that makes the frame start.
  task automatic check_frame(input int unsigned nbytes, input logic exp_underrun);
    int unsigned strobes = 0;
    for (int unsigned k = 0; k < PB; k++)
      for (int unsigned c = 0; c < BC; c++) begin
        @(negedge clk);
        check("pre_data", {31'd0, data_o}, {31'd0, ~k[0]});
        check("pre_strobe", {31'd0, bit_strobe_o}, {31'd0, c == 0});
        check("pre_busy", {31'd0, busy_o}, 32'd1);
        if (bit_strobe_o) strobes++;
      end
    for (int unsigned i = 0; i < nbytes; i++) begin
      logic [7:0] b;
      b = tx_q[i];
      for (int unsigned k = 0; k < 8; k++)
        for (int unsigned c = 0; c < BC; c++) begin
          @(negedge clk);
          check("dat_data", {31'd0, data_o}, {31'd0, b[k]});
          check("dat_strobe", {31'd0, bit_strobe_o}, {31'd0, c == 0});
          check("dat_underrun", {31'd0, underrun_o}, 32'd0);
          if (bit_strobe_o) strobes++;
        end
    end
    check("strobe_count", strobes, PB + 8 * nbytes);
    for (int unsigned c = 0; c < GB * BC; c++) begin
      @(negedge clk);
      check("gap_data", {31'd0, data_o}, {31'd0, IDL});
      check("gap_strobe", {31'd0, bit_strobe_o}, 32'd0);
      check("gap_busy", {31'd0, busy_o}, 32'd1);
      check("gap_underrun", {31'd0, underrun_o}, {31'd0, exp_underrun && c == 0});
    end
    @(negedge clk);
    check("idle_busy", {31'd0, busy_o}, 32'd0);
    check("idle_data", {31'd0, data_o}, {31'd0, IDL});
  endtask

  task automatic run_burst();
    int unsigned n;
    n = tx_q.size();
    send_byte(tx_q[0], n == 1);
    if (n == 1) byte_valid_i = 1'b0;
    fork
      begin
        for (int unsigned i = 1; i < n; i++) send_byte(tx_q[i], i == n - 1);
        byte_valid_i = 1'b0;
      end
      check_frame(n, 1'b0);
    join
  endtask

  initial begin
    resetn_i = 1'b0; byte_i = '0; byte_valid_i = 1'b0; byte_last_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", {31'd0, data_o}, {31'd0, IDL});
    check("rst_strobe", {31'd0, bit_strobe_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_underrun", {31'd0, underrun_o}, 32'd0);
    check("rst_ready", {31'd0, byte_ready_o}, 32'd1);
    resetn_i = 1'b1;
    repeat (2) @(negedge clk);

    // single frame 0xA5
    tx_q = {8'hA5};
    run_burst();
    repeat (3) @(negedge clk);

    // back-to-back with valid held high
    tx_q = {8'h00, 8'hFF, 8'h3C};
    run_burst();
    repeat (3) @(negedge clk);

    // starve after 0x12: underrun, flush drops 0x55/0x66, 0x77 starts fresh
    tx_q = {8'h12};
    send_byte(8'h12, 1'b0);
    byte_valid_i = 1'b0;
    check_frame(1, 1'b1);
    send_byte(8'h55, 1'b0);
    byte_valid_i = 1'b0;
    check("flush_ready0", {31'd0, byte_ready_o}, 32'd1);
    send_byte(8'h66, 1'b1);
    byte_valid_i = 1'b0;
    check("flush_ready1", {31'd0, byte_ready_o}, 32'd1);
    for (int unsigned c = 0; c < 3 * BC; c++) begin
      @(negedge clk);
      check("flush_nobusy", {31'd0, busy_o}, 32'd0);
    end
    tx_q = {8'h77};
    run_burst();

    // byte accepted during GAP starts right after IDLE is re-entered
    tx_q = {8'hC3};
    send_byte(8'hC3, 1'b1);
    byte_valid_i = 1'b0;
    fork
      check_frame(1, 1'b0);
      begin
        repeat ((PB + 8) * BC + 10) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        byte_valid_i = 1'b0;
      end
    join
    tx_q = {8'h5A};
    check_frame(1, 1'b0);

    // reset in the middle of a data bit
    send_byte(8'h96, 1'b1);
    byte_valid_i = 1'b0;
    repeat (PB * BC + 3 * BC + 7) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    resetn_i = 1'b0;
    #1;
    check("mid_rst_data", {31'd0, data_o}, {31'd0, IDL});
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_ready", {31'd0, byte_ready_o}, 32'd1);
    repeat (3) @(negedge clk);
    check("mid_rst_busy2", {31'd0, busy_o}, 32'd0);
    resetn_i = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", {31'd0, busy_o}, 32'd0);
    tx_q = {8'hE1};
    run_burst();

    // random multi-byte frame
    tx_q = {};
    for (int unsigned i = 0; i < 6; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    run_burst();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/chip_serializer_tx.md
# chip_serializer_tx

Transmit-side serializer for the Zigbee baseband. It accepts bytes over a valid/ready handshake and frames them with an alternating-bit preamble. Each frame goes out as an NRZ bitstream, LSB first, at one bit per BIT_CYCLES clocks, followed by a fixed idle gap. It drives the line sampled by the receive-side CDR, so the preamble exists to give that CDR's bang-bang phase detector transitions to lock on.

## Interface
- BIT_CYCLES, 25: clk cycles per transmitted bit; legal range 2..64.
- PREAMBLE_BITS, 32: preamble length in bits; legal range 2..255.
- GAP_BITS, 2: idle bit periods after each frame; legal range 1..255.
- IDLE_LEVEL, 1'b0: line level in IDLE, in GAP, and during reset.
- clk  in  1  system clock.
- resetn_i  in  1  reset, asynchronous, active-low.
- byte_i  in  8  payload byte.
- byte_valid_i  in  1  byte_i/byte_last_i valid.
- byte_last_i  in  1  marks the final byte of a frame.
- byte_ready_o  out  1  holding register empty; equals ~hold_valid.
- data_o  out  1  registered serial line.
- bit_strobe_o  out  1  one-cycle pulse on the first cycle of every preamble/data bit.
- busy_o  out  1  high in every state except IDLE.
- underrun_o  out  1  one-cycle pulse when a frame is aborted.

## Operation
- Transfer: a byte is accepted on any clk edge where byte_valid_i && byte_ready_o.
  - It is written to a 9-bit holding register {last, byte} and hold_valid is set.
  - While hold_valid is set, no byte is accepted.
- Counters:
  - cyc counts 0..BIT_CYCLES-1 and wraps.
  - bitcnt counts bits within the current phase and is wide enough for max(8, PREAMBLE_BITS, GAP_BITS).
  - A bit boundary is the edge where cyc == BIT_CYCLES-1.
- FSM states: IDLE, PREAMBLE, DATA, GAP, with these transitions:
  - IDLE -> PREAMBLE when hold_valid && !flush. cyc and bitcnt are cleared, and data_o takes preamble bit 0.
  - PREAMBLE emits bits alternating 1,0,1,0,…, so bit k = ~k[0].
  - PREAMBLE -> DATA on the boundary of preamble bit PREAMBLE_BITS-1:
    - the holding register moves to a shift register plus a last flag, and hold_valid clears;
    - data_o takes byte bit 0.
  - DATA shifts LSB first. On the boundary of bit 7:
    - if the last flag is set: go to GAP;
    - else if hold_valid: load the next byte and stay in DATA with no gap between bits;
    - else (underrun): pulse underrun_o, set flush, go to GAP.
  - GAP holds data_o = IDLE_LEVEL for GAP_BITS bit periods, then returns to IDLE.
- Flush: while flush is set, accepted bytes are discarded (hold_valid stays 0, so byte_ready_o stays 1).
  - Accepting a byte with byte_last_i=1 clears flush; that byte is also discarded.
  - While flush is set, IDLE does not start a frame.
- A byte accepted during GAP waits in the holding register. Its frame starts one cycle after GAP->IDLE; there is no direct GAP->PREAMBLE transition.
- bit_strobe_o pulses on the first cycle of every PREAMBLE and DATA bit, 8 pulses per byte. It never pulses in IDLE or GAP.

## Timing
- Reset values: data_o=IDLE_LEVEL, bit_strobe_o=0, busy_o=0, underrun_o=0, byte_ready_o=1, state=IDLE, flush=0.
  - Reset asserted mid-frame returns the block to these values immediately.
  - The holding register is emptied on reset; the byte in it is lost.
- Startup latency: if a byte is accepted at edge N while in IDLE:
  - PREAMBLE starts and busy_o rises at N+1; data_o and bit_strobe_o change at N+1;
  - the first data bit appears at N+1+PREAMBLE_BITS*BIT_CYCLES.
- Each bit is held for exactly BIT_CYCLES cycles. A byte lasts 8*BIT_CYCLES cycles.
- Holding register timing:
  - hold_valid clears on the load edge, so byte_ready_o rises on the following cycle.
  - To avoid underrun, upstream must supply the next byte before the bit-7 boundary of the current byte, giving 8*BIT_CYCLES-1 cycles of slack.
- underrun_o pulses in the cycle after the failing boundary.
- busy_o falls on the edge that enters IDLE.

## Test plan
- Single frame, byte 0xA5 with last=1, BIT_CYCLES=25, PREAMBLE_BITS=32, GAP_BITS=2:
  - 32 alternating bits starting at 1, then 1,0,1,0,0,1,0,1, each 25 cycles;
  - 40 strobes total;
  - busy_o low exactly 2*25 cycles after the last data bit ends.
- Back-to-back bytes 0x00, 0xFF, 0x3C (last), presented with byte_valid_i held high: contiguous 24-bit payload with no gap and no underrun_o.
- Starve after 0x12 with last=0:
  - underrun_o pulses once after the 8th data bit;
  - the next bytes 0x55 and 0x66 (last) are dropped with byte_ready_o=1;
  - no frame starts until a new byte 0x77 arrives, which produces a fresh preamble.
- Byte accepted during GAP: the frame starts exactly GAP_BITS*BIT_CYCLES+1 cycles after the previous frame's last bit ends.
- Reset pulse in the middle of a DATA bit: data_o=IDLE_LEVEL, busy_o=0, byte_ready_o=1 while resetn_i=0; a clean frame follows after release.
- Loopback into the receive CDR at BIT_CYCLES=25 with random 64-byte frames: the recovered bytes match the transmitted bytes after preamble lock.
